// File: rtl/relu_maxpool.sv
// ---------------------------------------------------------------------------
// relu_maxpool
//
// Purpose:
//   Post-processing stage behind the 5x5 conv engine. Each raw signed 32-bit
//   conv result arriving in raster order gets the per-map bias added, is
//   clamped at zero (ReLU), requantized by an arithmetic right shift and
//   saturated to int8. The int8 values are then max-pooled over 2x2 windows
//   with stride 2, producing an INSIZE/2 x INSIZE/2 map on a valid/ready
//   output stream.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high; a producer holding valid keeps its data stable until that
//   edge, and ready never depends on the same-side valid.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   bias         in   32  signed per-map bias, stable for a whole map
//   in_valid     in   1   in_data valid
//   in_ready     out  1   block accepts in_data this cycle
//   in_data      in   32  signed conv result, row-major raster
//   out_valid    out  1   out_data valid
//   out_ready    in   1   consumer accepts out_data this cycle
//   out_data     out  8   pooled result, 0..127
//   out_last     out  1   marks the final pooled pixel of a map
//   o_dbg_state  out  1   pooling FSM state (0 = even row, 1 = odd row)
// ---------------------------------------------------------------------------
module relu_maxpool #(
    parameter int INSIZE = 28,
    parameter int SHIFT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        o_dbg_state
);

    localparam int HALF = INSIZE / 2;
    localparam int CW   = $clog2(INSIZE);
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [CW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [7:0]       r_pair;
    logic [7:0]       r_linebuf [HALF];

    logic             w_xfer;
    logic             w_col_last;
    logic             w_row_last;
    logic [HW-1:0]    w_half;
    logic [7:0]       w_lb_rd;

    logic signed [32:0] w_sum;
    logic signed [32:0] w_relu;
    logic signed [32:0] w_q;
    logic [7:0]       w_p;
    logic [7:0]       w_max2;
    logic [7:0]       w_max3;

    logic             w_pair_load;
    logic             w_lb_write;
    logic             w_out_load;

    // Output side is a single register stage, so a new input can be taken
    // whenever that register is empty or is being drained this cycle.
    assign in_ready    = !out_valid || out_ready;
    assign w_xfer      = in_valid && in_ready;
    assign o_dbg_state = r_state;

    // Bias add at 33 bits so that no operand combination can wrap.
    assign w_sum  = $signed({in_data[31], in_data}) + $signed({bias[31], bias});
    assign w_relu = w_sum[32] ? 33'sd0 : w_sum;
    assign w_q    = w_relu >>> SHIFT;
    assign w_p    = (w_q > 33'sd127) ? 8'd127 : w_q[7:0];

    assign w_col_last = (r_col == CW'(INSIZE - 1));
    assign w_row_last = (r_row == CW'(INSIZE - 1));
    assign w_half     = HW'(r_col >> 1);
    assign w_lb_rd    = r_linebuf[w_half];

    // All pooled operands lie in 0..127, so unsigned compares are exact.
    assign w_max2 = (r_pair > w_p) ? r_pair : w_p;
    assign w_max3 = (w_lb_rd > w_max2) ? w_lb_rd : w_max2;

    // Pooling FSM: even rows fold horizontal pairs into the line buffer,
    // odd rows fold their pairs with the stored value to finish a window.
    always_comb begin
        w_next_state = r_state;
        w_pair_load  = 1'b0;
        w_lb_write   = 1'b0;
        w_out_load   = 1'b0;
        if (w_xfer) begin
            if (!r_col[0]) begin
                w_pair_load = 1'b1;
            end else if (r_state == EVEN_ROW) begin
                w_lb_write = 1'b1;
            end else begin
                w_out_load = 1'b1;
            end
            if (w_col_last) begin
                w_next_state = (r_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= EVEN_ROW;
            r_row     <= '0;
            r_col     <= '0;
            r_pair    <= 8'd0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_last  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_xfer) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_pair_load) begin
                r_pair <= w_p;
            end

            // A fresh result takes priority over draining; data and last
            // only change on a load, so they hold through backpressure.
            if (w_out_load) begin
                out_valid <= 1'b1;
                out_data  <= w_max3;
                out_last  <= w_row_last && w_col_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Line buffer is never cleared: every even row rewrites each entry
    // before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (rst_n && w_lb_write) begin
            r_linebuf[w_half] <= w_max2;
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// ---------------------------------------------------------------------------
// tb_relu_maxpool
//
// Two instances with INSIZE=4 share one input stream: dut_a uses SHIFT=0,
// dut_b uses SHIFT=8. A window-level reference model keeps every quantized
// pixel of the current map in an array and, whenever the bottom-right pixel
// of a 2x2 window is accepted, pushes the window maximum into each
// instance's expected queue. A monitor pops and compares on every output
// handshake.
// ---------------------------------------------------------------------------
module tb_relu_maxpool;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bias;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_last_a, dbg_a;
    logic [7:0]  out_data_a;
    logic        in_ready_b, out_valid_b, out_last_b, dbg_b;
    logic [7:0]  out_data_b;

    always #5 clk = ~clk;

    relu_maxpool #(.INSIZE(N), .SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_last(out_last_a), .o_dbg_state(dbg_a)
    );

    relu_maxpool #(.INSIZE(N), .SHIFT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_last(out_last_b), .o_dbg_state(dbg_b)
    );

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q_a[$];
    logic [8:0] exp_q_b[$];
    int         checks = 0;
    int         passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int         pix_cnt = 0;
    logic [7:0] map_a[N*N];
    logic [7:0] map_b[N*N];

    function automatic logic [7:0] quant(input logic [31:0] d, input logic [31:0] b, input int sh);
        longint s;
        s = longint'($signed(d)) + longint'($signed(b));
        if (s < 0) s = 0;
        s = s >> sh;
        return (s > 127) ? 8'd127 : 8'(s);
    endfunction

    function automatic logic [7:0] max4(input logic [7:0] w, input logic [7:0] x,
                                        input logic [7:0] y, input logic [7:0] z);
        logic [7:0] m;
        m = w;
        if (x > m) m = x;
        if (y > m) m = y;
        if (z > m) m = z;
        return m;
    endfunction

    task automatic model_accept(input logic [31:0] d);
        int row;
        int col;
        int tl;
        row = pix_cnt / N;
        col = pix_cnt % N;
        map_a[pix_cnt] = quant(d, bias, 0);
        map_b[pix_cnt] = quant(d, bias, 8);
        if ((row % 2 == 1) && (col % 2 == 1)) begin
            tl = (row - 1) * N + (col - 1);
            exp_q_a.push_back({pix_cnt == N*N-1,
                max4(map_a[tl], map_a[tl+1], map_a[tl+N], map_a[tl+N+1])});
            exp_q_b.push_back({pix_cnt == N*N-1,
                max4(map_b[tl], map_b[tl+1], map_b[tl+N], map_b[tl+N+1])});
        end
        pix_cnt = (pix_cnt + 1) % (N*N);
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send(input logic [31:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200 && !done; t++) begin
            #1;
            if (in_ready_a) begin
                model_accept(d);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check("send_timeout", 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_t1();
        for (int i = 0; i < N*N; i++) send(32'(i));
    endtask

    task automatic send_const(input logic [31:0] d);
        for (int i = 0; i < N*N; i++) send(d);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); t++)
            @(negedge clk);
        check("drain_a", 32'(exp_q_a.size()), 32'd0);
        check("drain_b", 32'(exp_q_b.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        check("rst_valid_a", 32'(out_valid_a), 32'd0);
        check("rst_valid_b", 32'(out_valid_b), 32'd0);
        exp_q_a.delete();
        exp_q_b.delete();
        pix_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- output-ready control ----------------
    int rdy_mode    = 0;   // 0: always ready, 1: random, 2: one 5-cycle stall
    int stall_left  = 0;
    bit stall_armed = 1'b0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                if (stall_armed && out_valid_a) begin
                    stall_armed = 1'b0;
                    stall_left  = 5;
                end
                out_ready = (stall_left == 0);
                if (stall_left > 0) begin
                    stall_left--;
                    #2;
                    check("t5_hold_data", 32'(out_data_a), 32'd5);
                    check("t5_in_ready", 32'(in_ready_a), 32'd0);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_ready && out_valid_a) begin
                if (exp_q_a.size() == 0) begin
                    checks++;
                    $display("FAIL a_unexpected: out_data=%0d with nothing expected at %0t",
                             out_data_a, $time);
                end else begin
                    e = exp_q_a.pop_front();
                    check("a_data", 32'(out_data_a), 32'(e[7:0]));
                    check("a_last", 32'(out_last_a), 32'(e[8]));
                end
            end
            if (rst_n && out_ready && out_valid_b) begin
                if (exp_q_b.size() == 0) begin
                    checks++;
                    $display("FAIL b_unexpected: out_data=%0d with nothing expected at %0t",
                             out_data_b, $time);
                end else begin
                    e = exp_q_b.pop_front();
                    check("b_data", 32'(out_data_b), 32'(e[7:0]));
                    check("b_last", 32'(out_last_b), 32'(e[8]));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        bias     = 32'd0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_valid_a", 32'(out_valid_a), 32'd0);
        check("reset_data_a",  32'(out_data_a),  32'd0);
        check("reset_last_a",  32'(out_last_a),  32'd0);
        check("reset_state_a", 32'(dbg_a),       32'd0);
        check("reset_valid_b", 32'(out_valid_b), 32'd0);
        check("reset_data_b",  32'(out_data_b),  32'd0);
        check("reset_ready_a", 32'(in_ready_a),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: ramp 0..15 -> 5,7,13,15
        bias = 32'd0;
        send_t1();
        drain();

        // T2: negative bias
        bias = -32'sd10;
        send_t1();
        drain();

        // T3: all negative -> zeros
        bias = 32'd0;
        send_const(-32'sd1000);
        drain();

        // T4: saturation in both shift settings
        send_const(32'h0010_0000);
        drain();

        // T5: 5-cycle stall after the first output
        rdy_mode    = 2;
        stall_armed = 1'b1;
        send_t1();
        drain();
        rdy_mode = 0;

        // T6: reset mid-map, then a full map, then two maps back to back
        for (int i = 0; i < 6; i++) send(32'(i));
        pulse_reset();
        send_t1();
        drain();
        for (int i = 0; i < 2*N*N; i++) send(32'(i % (N*N)));
        drain();

        // Random maps: random bias per map, random data, input gaps and
        // random output backpressure.
        rdy_mode = 1;
        for (int m = 0; m < 8; m++) begin
            bias = 32'($urandom_range(0, 6000)) - 32'd3000;
            for (int i = 0; i < N*N; i++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                if ($urandom_range(0, 7) == 0) send($urandom());
                else send(32'($urandom_range(0, 90000)) - 32'd20000);
            end
        end
        rdy_mode = 0;
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
